// File: rtl/z80_bus_arbiter.sv
// Round-robin bus arbiter for Z80-style masters, with registered grants and combinational bus muxing.
// Define Z80_BUS_ARBITER_TIMEOUT_EN to compile in the slave wait-timeout watchdog.
package z80_bus_pkg;
  typedef struct packed {
    logic [7:0]  dmaster;
    logic [15:0] addr;
    logic        inta;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int MASTER_QTY     = 2,
  parameter int SLAVE_QTY      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MASTER_QTY-1:0]         req,
  input  Z80MasterBus                   master_ins [MASTER_QTY],
  input  Z80SlaveBus                    slave_ins  [SLAVE_QTY],
  input  logic [$clog2(SLAVE_QTY)-1:0]  ssel,
  output Z80MasterBus                   master_out,
  output Z80SlaveBus                    slave_out,
  output logic [MASTER_QTY-1:0]         grant,
  output logic [$clog2(MASTER_QTY)-1:0] owner,
  output logic                          busy,
  output logic                          bus_err
);

  localparam int OW = $clog2(MASTER_QTY);

  if (MASTER_QTY < 2 || SLAVE_QTY < 2 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_params
    $error("z80_bus_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t                state_q, state_d;
  logic [MASTER_QTY-1:0] grant_q, grant_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_owner_q, last_owner_d;
  logic [OW-1:0]         cand, winner;
  logic                  found;
  Z80SlaveBus            routed;

  // Round-robin search starting just after the previous owner, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= MASTER_QTY; i++) begin
      cand = OW'((int'(last_owner_q) + i) % MASTER_QTY);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        if (found) begin
          state_d         = OWNED;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          state_d      = TURN;
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(MASTER_QTY - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign busy  = (state_q == OWNED);
  assign grant = grant_q;
  assign owner = owner_q;

  always_comb begin
    master_out = '0;
    routed     = '{dslave: 8'h00, mwait: 1'b1};
    if (busy) begin
      master_out = master_ins[owner_q];
      if (int'(ssel) < SLAVE_QTY) routed = slave_ins[ssel];
    end
  end

`ifdef Z80_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout;

  // A stalled slave is released by faking a ready cycle with all-ones data.
  always_comb begin
    timeout    = busy && !routed.mwait && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
    wait_cnt_d = (busy && !routed.mwait && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
    slave_out  = routed;
    if (timeout) slave_out = '{dslave: 8'hFF, mwait: 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= 8'd0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign bus_err = timeout;
`else
  assign slave_out = routed;
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed-vector bench for z80_bus_arbiter: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_z80_bus_arbiter;
  import z80_bus_pkg::*;

`ifdef Z80_BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  ssel;
  Z80MasterBus m_ins [2];
  Z80SlaveBus  s_ins [3];
  Z80MasterBus master_out;
  Z80SlaveBus  slave_out;
  logic [1:0]  grant;
  logic [0:0]  owner;
  logic        busy;
  logic        bus_err;

  localparam Z80MasterBus M0 = '{dmaster: 8'h11, addr: 16'h1000, inta: 1'b0};
  localparam Z80MasterBus M1 = '{dmaster: 8'h22, addr: 16'h2002, inta: 1'b1};

  z80_bus_arbiter #(.MASTER_QTY(2), .SLAVE_QTY(3), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .master_ins(m_ins), .slave_ins(s_ins),
    .ssel(ssel), .master_out(master_out), .slave_out(slave_out), .grant(grant),
    .owner(owner), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Expected fields describe outputs seen in the cycle the vector's inputs are applied:
  // registered outputs reflect the previous vector, bus muxing reflects this one.
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] ssel;
    logic       s2_mwait;
    logic [1:0] e_grant;
    logic       e_owner;
    logic       e_busy;
    logic       e_err;
    int         e_mo;
    logic [7:0] e_dslave;
    logic       e_mwait;
    int         id;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [1:0] rq, input logic [1:0] ss,
                              input logic mw, input logic [1:0] g, input logic o,
                              input logic b, input logic e, input int mo,
                              input logic [7:0] ds, input logic emw);
    vec_t v;
    v.rst = r; v.req = rq; v.ssel = ss; v.s2_mwait = mw;
    v.e_grant = g; v.e_owner = o; v.e_busy = b; v.e_err = e;
    v.e_mo = mo; v.e_dslave = ds; v.e_mwait = emw; v.id = vecs.size();
    vecs.push_back(v);
  endfunction

  // Monitor: compares every queued expectation away from the rising edge.
  initial begin
    vec_t v;
    Z80MasterBus emo;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        v   = exp_q.pop_front();
        emo = (v.e_mo == 1) ? M0 : (v.e_mo == 2) ? M1 : '0;
        check("grant",   v.id, 32'(grant),   32'(v.e_grant));
        check("busy",    v.id, 32'(busy),    32'(v.e_busy));
        check("bus_err", v.id, 32'(bus_err), 32'(v.e_err));
        if (v.e_busy) check("owner", v.id, 32'(owner), 32'(v.e_owner));
        check("master_out", v.id, 32'(master_out), 32'(emo));
        check("dslave",     v.id, 32'(slave_out.dslave), 32'(v.e_dslave));
        check("mwait",      v.id, 32'(slave_out.mwait),  32'(v.e_mwait));
      end
    end
  end

  initial begin
    logic e;
    reset = 1'b1; req = 2'b00; ssel = 2'd0;
    m_ins[0] = M0; m_ins[1] = M1;
    s_ins[0] = '{dslave: 8'hA0, mwait: 1'b1};
    s_ins[1] = '{dslave: 8'hB1, mwait: 1'b1};
    s_ins[2] = '{dslave: 8'h5A, mwait: 1'b1};

    //  rst req    ssel mw  grant  own busy err mo  dslave mwait
    add(1, 2'b00, 2'd0, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // reset state
    add(0, 2'b01, 2'd0, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // req ignored on reset edge
    add(0, 2'b01, 2'd0, 1, 2'b01, 0, 1, 0, 1, 8'hA0, 1);  // 1-cycle grant latency
    add(0, 2'b11, 2'd0, 1, 2'b01, 0, 1, 0, 1, 8'hA0, 1);
    add(0, 2'b10, 2'd0, 1, 2'b01, 0, 1, 0, 1, 8'hA0, 1);  // no preemption by master 1
    add(0, 2'b10, 2'd0, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // TURN gap
    add(0, 2'b10, 2'd2, 1, 2'b10, 1, 1, 0, 2, 8'h5A, 1);  // handover to master 1
    add(0, 2'b10, 2'd3, 1, 2'b10, 1, 1, 0, 2, 8'h00, 1);  // ssel out of range
    add(0, 2'b10, 2'd1, 1, 2'b10, 1, 1, 0, 2, 8'hB1, 1);
    // Slave 2 stalls; with the watchdog every 16th stalled cycle is forced ready.
    // Reset lands at i=106 while the wait count is 10.
    for (int i = 0; i <= 106; i++) begin
      e = TO_EN && (i % 16 == 15);
      add(i == 106, 2'b10, 2'd2, 0, 2'b10, 1, 1, e, 2, e ? 8'hFF : 8'h5A, e);
    end
    add(0, 2'b11, 2'd2, 0, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // reset applied mid-ownership
    add(0, 2'b11, 2'd2, 0, 2'b01, 0, 1, 0, 1, 8'h5A, 0);  // master 0 wins after reset
    add(0, 2'b00, 2'd2, 1, 2'b01, 0, 1, 0, 1, 8'h5A, 1);
    add(0, 2'b00, 2'd2, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // TURN
    add(0, 2'b00, 2'd2, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // IDLE
    add(0, 2'b10, 2'd2, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);
    add(0, 2'b11, 2'd2, 1, 2'b10, 1, 1, 0, 2, 8'h5A, 1);  // master 1 from IDLE
    add(0, 2'b01, 2'd2, 1, 2'b10, 1, 1, 0, 2, 8'h5A, 1);
    add(0, 2'b01, 2'd2, 1, 2'b00, 0, 0, 0, 0, 8'h00, 1);  // TURN
    add(0, 2'b01, 2'd2, 1, 2'b01, 0, 1, 0, 1, 8'h5A, 1);  // wrap back to master 0

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      reset = vecs[k].rst;
      req   = vecs[k].req;
      ssel  = vecs[k].ssel;
      s_ins[2].mwait = vecs[k].s2_mwait;
      exp_q.push_back(vecs[k]);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drain", -1, 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
